// File: rtl/quant_relu_if.sv
// Handshake and result bundle for the quant_relu requantize + ReLU block.
// The master side issues start/a and observes the status and result lines.
// The slave side is the quant_relu datapath itself.
interface quant_relu_if;
    logic               start;
    logic signed [63:0] a;
    logic               busy;
    logic signed [8:0]  num_quant;
    logic               quant_ok;
    logic signed [7:0]  out;
    logic               done;

    modport master (
        output start,
        output a,
        input  busy,
        input  num_quant,
        input  quant_ok,
        input  out,
        input  done
    );

    modport slave (
        input  start,
        input  a,
        output busy,
        output num_quant,
        output quant_ok,
        output out,
        output done
    );
endinterface

// File: rtl/quant_relu.sv
// Requantization followed by ReLU for one convolution accumulator.
// The flow is: multiply by Q, round and shift by SHIFT, saturate to 9 bits, clamp to 0..127.
// A five-state FSM runs one request at a time.
// Every output comes straight from a register, so there is no path from input to output.
module quant_relu #(
    parameter logic [31:0] Q     = 32'd2014687024,
    parameter int unsigned SHIFT = 31
) (
    input  logic           clk,
    input  logic           rst,
    quant_relu_if.slave    bus
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MUL  = 3'd1,
        RND  = 3'd2,
        QSAT = 3'd3,
        RELU = 3'd4
    } state_t;

    // Rounding bias is one half of an output LSB (round half toward +infinity).
    localparam logic signed [96:0] RND_ADD = 97'sd1 <<< (SHIFT - 32'd1);
    localparam logic signed [96:0] SAT_HI  = 97'sd255;
    localparam logic signed [96:0] SAT_LO  = -97'sd256;
    localparam logic signed [8:0]  NQ_MAX  = 9'sh0FF;
    localparam logic signed [8:0]  NQ_MIN  = 9'sh100;

    state_t             state_r;
    logic               busy_r;
    logic signed [63:0] a_r;
    logic signed [96:0] p_r;
    logic signed [96:0] r_r;
    logic signed [8:0]  nq_r;
    logic               qok_r;
    logic signed [7:0]  out_r;
    logic               done_r;

    logic signed [96:0] a_ext_s;
    logic signed [96:0] q_ext_s;
    logic signed [96:0] prod_s;
    logic signed [96:0] rnd_s;

    // Clamp the full-width rounded value into the signed 9-bit range; never wraps.
    function automatic logic signed [8:0] sat9(input logic signed [96:0] v);
        logic signed [8:0] res;
        if (v > SAT_HI) begin
            res = NQ_MAX;
        end else if (v < SAT_LO) begin
            res = NQ_MIN;
        end else begin
            res = v[8:0];
        end
        return res;
    endfunction

    // ReLU with an upper clamp at 127 so the result fits a signed byte.
    function automatic logic signed [7:0] relu8(input logic signed [8:0] v);
        logic signed [7:0] res;
        if (v[8]) begin
            res = 8'sd0;
        end else if (v[7]) begin
            res = 8'sd127;
        end else begin
            res = {1'b0, v[6:0]};
        end
        return res;
    endfunction

    // Arithmetic on registered operands: full 97-bit product, then the rounded arithmetic shift.
    always_comb begin
        a_ext_s = {{33{a_r[63]}}, a_r};
        q_ext_s = {65'd0, Q};
        prod_s  = a_ext_s * q_ext_s;
        rnd_s   = (p_r + RND_ADD) >>> SHIFT;
    end

    // Control FSM and all datapath/output registers; an unknown state code falls back to IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            a_r     <= 64'sd0;
            p_r     <= 97'sd0;
            r_r     <= 97'sd0;
            nq_r    <= 9'sd0;
            qok_r   <= 1'b0;
            out_r   <= 8'sd0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r     <= bus.a;
                        qok_r   <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= MUL;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                MUL: begin
                    p_r     <= prod_s;
                    state_r <= RND;
                end
                RND: begin
                    r_r     <= rnd_s;
                    state_r <= QSAT;
                end
                QSAT: begin
                    nq_r    <= sat9(r_r);
                    qok_r   <= 1'b1;
                    state_r <= RELU;
                end
                RELU: begin
                    out_r   <= relu8(nq_r);
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.num_quant = nq_r;
    assign bus.quant_ok  = qok_r;
    assign bus.out       = out_r;
    assign bus.done      = done_r;

endmodule

// File: tb/tb_quant_relu.sv
// Self-checking bench for quant_relu.
// Expected values come from a table of hand-computed constants.
// Each accepted start queues its expectation, and a monitor pops and checks it on every done pulse.
module tb_quant_relu;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    quant_relu_if bus();

    quant_relu #(
        .Q     (32'd2014687024),
        .SHIFT (31)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic signed [63:0] a;
        logic signed [8:0]  nq;
        logic signed [7:0]  o;
    } vec_t;

    typedef struct {
        logic signed [8:0] nq;
        logic signed [7:0] o;
    } exp_t;

    localparam int N_VEC = 16;

    vec_t tbl [N_VEC];
    exp_t sb [$];
    int   n_cmp    = 0;
    int   n_err    = 0;
    int   done_cnt = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (bus.done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 expected no pending result");
            end else begin
                e = sb.pop_front();
                check("sb_out", bus.out, e.o);
                check("sb_num_quant", bus.num_quant, e.nq);
            end
        end
    end

    // This task is entered just after a negedge.
    // It drives one start and checks the cycle-exact timeline up to one cycle after done.
    // With poke set, it also pulses start while busy, and that second start must be ignored.
    task automatic run_op(input logic signed [63:0] av, input logic signed [8:0] nq,
                          input logic signed [7:0] o, input bit poke);
        exp_t ev;
        ev.nq = nq;
        ev.o  = o;
        bus.start = 1'b1;
        bus.a     = av;
        sb.push_back(ev);
        @(negedge clk);                       // after edge N (accept)
        bus.start = 1'b0;
        bus.a     = ~av;
        check("busy_after_accept", bus.busy, 1);
        check("quant_ok_cleared", bus.quant_ok, 0);
        if (poke) begin
            bus.start = 1'b1;
            bus.a     = 64'sd5;
        end
        @(negedge clk);                       // after edge N+1
        bus.start = 1'b0;
        check("busy_mul", bus.busy, 1);
        @(negedge clk);                       // after edge N+2
        check("quant_ok_early", bus.quant_ok, 0);
        @(negedge clk);                       // after edge N+3
        check("quant_ok_set", bus.quant_ok, 1);
        check("num_quant", bus.num_quant, nq);
        check("done_early", bus.done, 0);
        @(negedge clk);                       // after edge N+4
        check("done_pulse", bus.done, 1);
        check("busy_cleared", bus.busy, 0);
        check("out", bus.out, o);
        @(negedge clk);                       // after edge N+5
        check("done_one_cycle", bus.done, 0);
        check("out_hold", bus.out, o);
        check("quant_ok_hold", bus.quant_ok, 1);
    endtask

    initial begin
        int base;
        tbl[0]  = '{64'sd100,   9'sd94,   8'sd94};
        tbl[1]  = '{64'sd200,   9'sd188,  8'sd127};
        tbl[2]  = '{-64'sd50,   -9'sd47,  8'sd0};
        tbl[3]  = '{64'sd1000,  9'sd255,  8'sd127};
        tbl[4]  = '{-64'sd1000, 9'sh100,  8'sd0};
        tbl[5]  = '{64'sd0,     9'sd0,    8'sd0};
        tbl[6]  = '{64'sd1,     9'sd1,    8'sd1};
        tbl[7]  = '{-64'sd1,    -9'sd1,   8'sd0};
        tbl[8]  = '{64'sd3,     9'sd3,    8'sd3};
        tbl[9]  = '{64'sd135,   9'sd127,  8'sd127};
        tbl[10] = '{64'sd136,   9'sd128,  8'sd127};
        tbl[11] = '{64'sd272,   9'sd255,  8'sd127};
        tbl[12] = '{64'sd273,   9'sd255,  8'sd127};
        tbl[13] = '{-64'sd273,  9'sh100,  8'sd0};
        tbl[14] = '{64'sh7FFF_FFFF_FFFF_FFFF, 9'sd255, 8'sd127};
        tbl[15] = '{64'sh8000_0000_0000_0000, 9'sh100, 8'sd0};

        rst       = 1'b0;
        bus.start = 1'b0;
        bus.a     = 64'sd0;
        repeat (2) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_num_quant", bus.num_quant, 0);
        check("rst_quant_ok", bus.quant_ok, 0);
        check("rst_out", bus.out, 0);
        check("rst_done", bus.done, 0);

        // Release reset and start on the very first rising edge afterwards.
        rst = 1'b1;
        for (int i = 0; i < N_VEC; i++) begin
            run_op(tbl[i].a, tbl[i].nq, tbl[i].o, 1'b0);
        end

        // Outputs hold while idle.
        repeat (3) @(negedge clk);
        check("idle_num_quant_hold", bus.num_quant, tbl[N_VEC-1].nq);
        check("idle_out_hold", bus.out, tbl[N_VEC-1].o);
        check("idle_quant_ok_hold", bus.quant_ok, 1);
        check("idle_busy", bus.busy, 0);

        // A start issued while busy is dropped: one result, one done.
        base = done_cnt;
        run_op(64'sd200, 9'sd188, 8'sd127, 1'b1);
        repeat (6) @(negedge clk);
        check("single_done_on_poke", done_cnt - base, 1);

        // Reset two cycles into an operation aborts it without a done pulse.
        bus.start = 1'b1;
        bus.a     = 64'sd100;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        base = done_cnt;
        rst = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_num_quant", bus.num_quant, 0);
        check("abort_quant_ok", bus.quant_ok, 0);
        check("abort_out", bus.out, 0);
        check("abort_done", bus.done, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        run_op(-64'sd50, -9'sd47, 8'sd0, 1'b0);
        check("abort_done_count", done_cnt - base, 1);

        check("scoreboard_empty", sb.size(), 0);
        check("total_done_pulses", done_cnt, N_VEC + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
